mod_mul_sched: RTL

Round-robin scheduler that shares one sequential `mod_mul` unit (secp256k1 field multiply, fixed multi-hundred-cycle latency) among `NUM_REQ` requesters in the ECDSA point-arithmetic layer. It accepts operand pairs over valid/ready, issues one multiply at a time, and returns each result to the requester that issued it. It also enforces fairness and an optional completion watchdog.

---
 rtl/ecdsa_pkg.sv | 19 +
 rtl/rr_pick.sv | 28 ++
 rtl/mod_mul_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ecdsa_pkg.sv
// Shared constants and types for the ECDSA point-arithmetic layer.
package ecdsa_pkg;

    localparam int unsigned FE_W = 256;

    // secp256k1 field prime
    localparam logic [FE_W-1:0] P_CONST =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam int unsigned MODMUL_LATENCY = 280;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of req at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_onehot,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned idx;
            idx = (32'(ptr) + i) % NUM_REQ;
            if (gnt_onehot == '0 && req[idx]) begin
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = IdxW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mod_mul_sched.sv
// Round-robin scheduler sharing one sequential mod_mul among NUM_REQ requesters.
// Optional completion watchdog enabled by defining MODMUL_SCHED_TIMEOUT_EN.
module mod_mul_sched
    import ecdsa_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 320
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FE_W-1:0] req_a,
    input  logic [NUM_REQ*FE_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [FE_W-1:0]         rsp_data,
    output logic                    rsp_err,
    output logic                    mm_start,
    output logic [FE_W-1:0]         mm_a,
    output logic [FE_W-1:0]         mm_b,
    input  logic [FE_W-1:0]         mm_r,
    input  logic                    mm_done,
    output logic                    busy
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    sched_state_t    state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [FE_W-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d;
    logic [FE_W-1:0] rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_any;
    logic               grant_ok, grant, timeout;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .gnt_onehot(pick_onehot),
        .gnt_idx   (pick_idx),
        .any       (pick_any)
    );

    assign grant = (state_q == StIdle) && pick_any && grant_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    gnt_d   = pick_idx;
                    mm_a_d  = req_a[int'(pick_idx)*FE_W +: FE_W];
                    mm_b_d  = req_b[int'(pick_idx)*FE_W +: FE_W];
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (mm_done) begin
                    rsp_data_d = mm_r;
                    state_d    = StResp;
                end else if (timeout) begin
                    rsp_data_d = '0;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (rsp_ready[gnt_q]) begin
                    rr_ptr_d = (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // req_ready is combinational from req_valid; keep it low while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        mm_start  = 1'b0;
        busy      = (state_q != StIdle);
        if (grant && rst_n) begin
            req_ready = pick_onehot;
        end
        if (state_q == StIssue) begin
            mm_start = 1'b1;
        end
        if (state_q == StResp) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign rsp_data = rsp_data_q;

`ifdef MODMUL_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drain_q, drain_d, err_q, err_d;

    // Counter starts at 0 in ISSUE; after an abort it times the drain period in IDLE.
    assign timeout  = (state_q == StWait) && !mm_done && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign grant_ok = !drain_q || (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d   = '0;
        drain_d = drain_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (drain_q) begin
                    if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                        drain_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StIssue, StWait: cnt_d = cnt_q + 1'b1;
            default: cnt_d = '0;
        endcase
        if (state_q == StWait && mm_done) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d   = 1'b1;
            drain_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign grant_ok           = 1'b1;
    assign rsp_err            = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

endmodule
